// File: rtl/execute_stage_pipe_if.sv
// Handshake and operand bundle between decode/regfile read, the execute stage and memory.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the execute stage connects as slave.
interface execute_stage_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_aluop;
  logic [SHAMT_W-1:0] in_shamt;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [WIDTH-1:0]   in_pc;
  logic [WIDTH-1:0]   in_offset;
  logic               in_immed;
  logic               in_bne;
  logic               in_blt;
  logic               in_mult;
  logic               in_div;
  logic               in_exc_en;
  logic [4:0]         in_rd;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic [4:0]         out_rd;
  logic [WIDTH-1:0]   out_exception;
  logic               out_branch;
  logic               out_taken;
  logic [WIDTH-1:0]   out_target;
  logic               md_busy;

  modport master (
    output in_valid, in_aluop, in_shamt, in_a, in_b, in_pc, in_offset, in_immed,
           in_bne, in_blt, in_mult, in_div, in_exc_en, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_exception, out_branch,
           out_taken, out_target, md_busy
  );

  modport slave (
    input  in_valid, in_aluop, in_shamt, in_a, in_b, in_pc, in_offset, in_immed,
           in_bne, in_blt, in_mult, in_div, in_exc_en, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_exception, out_branch,
           out_taken, out_target, md_busy
  );
endinterface

// File: rtl/execute_stage_pipe.sv
// Execute stage: 1-cycle ALU/branch ops plus iterative signed mult/div (divider built only with EXECUTE_DIV_EN).
// Latency: ALU, branch and trapped divides 1 cycle; multiply/divide WIDTH+2 cycles from accept to out_valid.
// Backpressure: single output register holds while out_valid && !out_ready; in_ready low when full, busy or flushing.
module execute_stage_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic                 clock,
  input logic                 reset,
  input logic                 flush,
  execute_stage_pipe_if.slave io
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] EXC_ADD  = WIDTH'(1);
  localparam logic [WIDTH-1:0] EXC_IMM  = WIDTH'(2);
  localparam logic [WIDTH-1:0] EXC_SUB  = WIDTH'(3);
  localparam logic [WIDTH-1:0] EXC_MUL  = WIDTH'(4);
  localparam logic [WIDTH-1:0] EXC_DIV0 = WIDTH'(5);

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic               md_neg_q;
  logic [4:0]         md_rd_q;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dvsr_q;
`ifdef EXECUTE_DIV_EN
  logic               md_div_q;
  logic               div_zero;
  logic [WIDTH:0]     rem_sh;
`endif

  logic               out_valid_q;
  logic [WIDTH-1:0]   out_result_q;
  logic [4:0]         out_rd_q;
  logic [WIDTH-1:0]   out_exc_q;
  logic               out_branch_q;
  logic               out_taken_q;
  logic [WIDTH-1:0]   out_target_q;

  logic               out_free, accept, op_mult, op_div;
  logic               md_start, div_trap, alu_load;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   sum_add, sum_sub, alu_res, exc_code, br_target;
  logic               ovf_add, ovf_sub, alu_ovf, is_branch, br_taken;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0]   md_res, md_exc;

  // Output register can take a new value when empty or draining this cycle.
  assign out_free    = !out_valid_q || io.out_ready;
  // Gated by reset so the stage advertises nothing while held in reset.
  assign io.in_ready = reset && (state_q == IDLE) && out_free && !flush;
  assign accept      = io.in_valid && io.in_ready;
  assign op_mult     = io.in_mult;
  assign op_div      = io.in_div && !io.in_mult;
  assign alu_load    = accept && !op_mult && !op_div;

`ifdef EXECUTE_DIV_EN
  // Divide by zero never enters the iterative loop; it traps straight into the output register.
  assign div_zero = op_div && (io.in_b == '0);
  assign md_start = accept && (op_mult || (op_div && !div_zero));
  assign div_trap = accept && div_zero;
`else
  // Without the divider every divide traps as an unimplemented op.
  assign md_start = accept && op_mult;
  assign div_trap = accept && op_div;
`endif

  assign mag_a = io.in_a[WIDTH-1] ? -io.in_a : io.in_a;
  assign mag_b = io.in_b[WIDTH-1] ? -io.in_b : io.in_b;

  assign sum_add   = io.in_a + io.in_b;
  assign sum_sub   = io.in_a - io.in_b;
  assign ovf_add   = (io.in_a[WIDTH-1] == io.in_b[WIDTH-1]) && (sum_add[WIDTH-1] != io.in_a[WIDTH-1]);
  assign ovf_sub   = (io.in_a[WIDTH-1] != io.in_b[WIDTH-1]) && (sum_sub[WIDTH-1] != io.in_a[WIDTH-1]);
  assign is_branch = io.in_bne || io.in_blt;
  assign br_taken  = (io.in_bne && (io.in_a != io.in_b)) ||
                     (io.in_blt && ($signed(io.in_a) < $signed(io.in_b)));
  assign br_target = io.in_pc + (io.in_offset << 2);

  // Single-cycle ALU result and its overflow flag; unknown opcodes give zero.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (io.in_aluop)
      5'd0: begin alu_res = sum_add; alu_ovf = ovf_add; end
      5'd1: begin alu_res = sum_sub; alu_ovf = ovf_sub; end
      5'd2: alu_res = io.in_a & io.in_b;
      5'd3: alu_res = io.in_a | io.in_b;
      5'd4: alu_res = io.in_a << io.in_shamt;
      5'd5: alu_res = $signed(io.in_a) >>> io.in_shamt;
      default: alu_res = '0;
    endcase
  end

  // Overflow is only reported when the op allows it; immediate form takes priority over sub.
  always_comb begin
    exc_code = '0;
    if (alu_ovf && io.in_exc_en) begin
      if (io.in_immed)             exc_code = EXC_IMM;
      else if (io.in_aluop == 5'd1) exc_code = EXC_SUB;
      else                          exc_code = EXC_ADD;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum = lo_q[0] ? (hi_q + {1'b0, dvsr_q}) : hi_q;
    hi_d    = {1'b0, mul_sum[WIDTH:1]};
    lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef EXECUTE_DIV_EN
    rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    if (md_div_q) begin
      if (rem_sh >= {1'b0, dvsr_q}) begin
        hi_d = rem_sh - {1'b0, dvsr_q};
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh;
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Sign fix-up of the magnitude result, used when DONE loads the output register.
  always_comb begin
    prod_mag = {hi_q[WIDTH-1:0], lo_q};
    prod_s   = md_neg_q ? -prod_mag : prod_mag;
    md_res   = prod_s[WIDTH-1:0];
    md_exc   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}}) ? EXC_MUL : '0;
`ifdef EXECUTE_DIV_EN
    // Quotient magnitude sits in lo; most-negative / -1 wraps back to most-negative.
    if (md_div_q) begin
      md_res = md_neg_q ? -lo_q : lo_q;
      md_exc = '0;
    end
`endif
  end

  // Mult/div FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: exactly WIDTH BUSY cycles, DONE waits for room in the output register; flush wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = BUSY;
      BUSY:    if (cnt_q == SHAMT_W'(WIDTH - 1)) state_d = DONE;
      DONE:    if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Operand capture on start, then one iteration per BUSY cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      md_neg_q <= 1'b0;
      md_rd_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvsr_q   <= '0;
`ifdef EXECUTE_DIV_EN
      md_div_q <= 1'b0;
`endif
    end else if (md_start) begin
      cnt_q    <= '0;
      md_neg_q <= io.in_a[WIDTH-1] ^ io.in_b[WIDTH-1];
      md_rd_q  <= io.in_rd;
      hi_q     <= '0;
      lo_q     <= op_mult ? mag_b : mag_a;
      dvsr_q   <= op_mult ? mag_a : mag_b;
`ifdef EXECUTE_DIV_EN
      md_div_q <= !op_mult;
`endif
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Output register: ALU/trap loads on accept, DONE loads mult/div, otherwise drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_exc_q    <= '0;
      out_branch_q <= 1'b0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (alu_load) begin
      out_valid_q  <= 1'b1;
      out_result_q <= alu_res;
      out_rd_q     <= io.in_rd;
      out_exc_q    <= exc_code;
      out_branch_q <= is_branch;
      out_taken_q  <= br_taken;
      out_target_q <= br_target;
    end else if (div_trap) begin
      out_valid_q  <= 1'b1;
      out_result_q <= '0;
      out_rd_q     <= io.in_rd;
      out_exc_q    <= EXC_DIV0;
      out_branch_q <= 1'b0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
    end else if ((state_q == DONE) && out_free) begin
      out_valid_q  <= 1'b1;
      out_result_q <= md_res;
      out_rd_q     <= md_rd_q;
      out_exc_q    <= md_exc;
      out_branch_q <= 1'b0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.out_valid     = out_valid_q;
  assign io.out_result    = out_result_q;
  assign io.out_rd        = out_rd_q;
  assign io.out_exception = out_exc_q;
  assign io.out_branch    = out_branch_q;
  assign io.out_taken     = out_taken_q;
  assign io.out_target    = out_target_q;
  assign io.md_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: vector table through a scoreboard, plus backpressure, flush and reset sequences.
// Latency: checks 1-cycle ALU/trap and WIDTH+2-cycle mult/div from accept to out_valid.
// Backpressure: holds out_ready low to check output stability and same-cycle drain/accept.
module tb_execute_stage_pipe;

  localparam logic [5:0] C_IMM = 6'b100000;
  localparam logic [5:0] C_BNE = 6'b010000;
  localparam logic [5:0] C_BLT = 6'b001000;
  localparam logic [5:0] C_MUL = 6'b000100;
  localparam logic [5:0] C_DIV = 6'b000010;
  localparam logic [5:0] C_EXC = 6'b000001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  execute_stage_pipe_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  execute_stage_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  typedef struct {
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [31:0] a, b, pc, off;
    logic [5:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] res, exc;
    logic        br, tk;
    logic [31:0] tgt;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res, exc, tgt;
    logic        br, tk;
    logic [4:0]  rd;
    int          lat, acc, id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] sh,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] off,
                              input logic [5:0] ctl, input logic [31:0] res,
                              input logic [31:0] exc, input logic br, input logic tk,
                              input logic [31:0] tgt, input int lat);
    vec_t v;
    v.aluop = op; v.shamt = sh; v.a = a; v.b = b; v.pc = pc; v.off = off;
    v.ctl = ctl; v.rd = 5'd0; v.res = res; v.exc = exc; v.br = br; v.tk = tk;
    v.tgt = tgt; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for the falling edge and retires one scoreboard entry if a transfer is pending.
  task automatic sample();
    exp_t e;
    @(negedge clock);
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: result 0x%08h with nothing outstanding", bus.out_result);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d.result", e.id), bus.out_result, e.res);
        chk($sformatf("v%0d.exception", e.id), bus.out_exception, e.exc);
        chk($sformatf("v%0d.rd", e.id), 32'(bus.out_rd), 32'(e.rd));
        chk($sformatf("v%0d.branch", e.id), 32'(bus.out_branch), 32'(e.br));
        chk($sformatf("v%0d.taken", e.id), 32'(bus.out_taken), 32'(e.tk));
        chk($sformatf("v%0d.target", e.id), bus.out_target, e.tgt);
        if (e.lat > 0) chk($sformatf("v%0d.latency", e.id), 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_aluop  = v.aluop;
    bus.in_shamt  = v.shamt;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_pc     = v.pc;
    bus.in_offset = v.off;
    bus.in_immed  = v.ctl[5];
    bus.in_bne    = v.ctl[4];
    bus.in_blt    = v.ctl[3];
    bus.in_mult   = v.ctl[2];
    bus.in_div    = v.ctl[1];
    bus.in_exc_en = v.ctl[0];
    bus.in_rd     = v.rd;
  endtask

  function automatic exp_t to_exp(input vec_t v, input int id, input int acc);
    exp_t e;
    e.res = v.res; e.exc = v.exc; e.tgt = v.tgt; e.br = v.br; e.tk = v.tk;
    e.rd = v.rd; e.lat = v.lat; e.acc = acc; e.id = id;
    return e;
  endfunction

  // Presents one op until accepted (bounded), optionally recording its expected result.
  task automatic send(input vec_t v, input bit push, input int id);
    bit acc = 1'b0;
    drive(v);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      sample();
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout v%0d: in_ready never rose", id);
    end else if (push) begin
      sb.push_back(to_exp(v, id, cyc));
    end
  endtask

  task automatic drain(input int id);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      sample();
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout v%0d: %0d results outstanding", id, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    int   cnt;

    // op sh  a             b             pc        off           ctl          res           exc br tk tgt      lat
    tbl.push_back(mk(0, 0, 32'h7FFFFFFF, 32'h1,        32'h0,   32'h0,        C_EXC,         32'h80000000, 1, 0, 0, 32'h0,   1));
    tbl.push_back(mk(1, 0, 32'd5,        32'd7,        32'h0,   32'h0,        6'd0,          32'hFFFFFFFE, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 0, 32'h7FFFFFFF, 32'h1,        32'h0,   32'h0,        C_EXC | C_IMM, 32'h80000000, 2, 0, 0, 32'h0,   1));
    tbl.push_back(mk(1, 0, 32'h80000000, 32'h1,        32'h0,   32'h0,        C_EXC,         32'h7FFFFFFF, 3, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 0, 32'h7FFFFFFF, 32'h1,        32'h0,   32'h0,        6'd0,          32'h80000000, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(2, 0, 32'hF0F0,     32'hFF00,     32'h0,   32'h0,        6'd0,          32'hF000,     0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(3, 0, 32'hF0F0,     32'hFF00,     32'h0,   32'h0,        6'd0,          32'hFFF0,     0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(4, 4, 32'h1,        32'h0,        32'h0,   32'h0,        6'd0,          32'h10,       0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(4, 31, 32'h3,       32'h0,        32'h0,   32'h0,        6'd0,          32'h80000000, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(5, 4, 32'h80000000, 32'h0,        32'h0,   32'h0,        6'd0,          32'hF8000000, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(9, 0, 32'd5,        32'd6,        32'h0,   32'h0,        6'd0,          32'h0,        0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 0, 32'd1,        32'd2,        32'h100, 32'hFFFFFFFE, C_BNE,         32'd3,        0, 1, 1, 32'hF8,  1));
    tbl.push_back(mk(0, 0, 32'd5,        32'd5,        32'h200, 32'd3,        C_BLT,         32'd10,       0, 1, 0, 32'h20C, 1));
    tbl.push_back(mk(1, 0, 32'hFFFFFFFF, 32'd1,        32'h40,  32'h0,        C_BLT,         32'hFFFFFFFE, 0, 1, 1, 32'h40,  1));
    tbl.push_back(mk(0, 0, 32'd4,        32'd4,        32'h1000, 32'hFFFFFFFF, C_BNE,        32'd8,        0, 1, 0, 32'hFFC, 1));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFD, 32'd7,        32'h0,   32'h0,        C_MUL,         32'hFFFFFFEB, 0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'h10000,    32'h10000,    32'h0,   32'h0,        C_MUL,         32'h0,        4, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,   32'h0,        C_MUL,         32'd1,        0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'd6,        32'd7,        32'h0,   32'h0,        C_MUL | C_DIV, 32'd42,       0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'h80000000, 32'd1,        32'h0,   32'h0,        C_MUL,         32'h80000000, 0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h0,   32'h0,        C_MUL,         32'h80000000, 4, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'd9,        32'd0,        32'h0,   32'h0,        C_DIV,         32'h0,        5, 0, 0, 32'h0,   1));
`ifdef EXECUTE_DIV_EN
    tbl.push_back(mk(0, 0, 32'hFFFFFFF9, 32'd2,        32'h0,   32'h0,        C_DIV,         32'hFFFFFFFD, 0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h0,   32'h0,        C_DIV,         32'h80000000, 0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'd9,        32'd3,        32'h0,   32'h0,        C_DIV,         32'd3,        0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'd100,      32'hFFFFFFF9, 32'h0,   32'h0,        C_DIV,         32'hFFFFFFF2, 0, 0, 0, 32'h0,  34));
    tbl.push_back(mk(0, 0, 32'd3,        32'd9,        32'h0,   32'h0,        C_DIV,         32'h0,        0, 0, 0, 32'h0,  34));
`else
    tbl.push_back(mk(0, 0, 32'hFFFFFFF9, 32'd2,        32'h0,   32'h0,        C_DIV,         32'h0,        5, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 0, 32'd9,        32'd3,        32'h0,   32'h0,        C_DIV,         32'h0,        5, 0, 0, 32'h0,   1));
`endif

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0));

    // Reset state, then release.
    #1 reset = 1'b0;
    #2;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_md_busy", 32'(bus.md_busy), 32'd0);
    chk("reset_out_result", bus.out_result, 32'd0);
    chk("reset_out_exception", bus.out_exception, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    sample();
    chk("reset_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Vector table through the scoreboard.
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.rd = 5'(i + 1);
      send(v, 1'b1, i);
      drain(i);
      chk($sformatf("v%0d.md_busy_after", i), 32'(bus.md_busy), 32'd0);
    end

    // Backpressure: result held for 3 cycles, then drain and accept on the same edge.
    bus.out_ready = 1'b0;
    v = mk(0, 0, 32'd1, 32'd1, 0, 0, 6'd0, 32'd2, 0, 0, 0, 0, 0);
    v.rd = 5'd20;
    send(v, 1'b1, 100);
    v = mk(0, 0, 32'd2, 32'd2, 0, 0, 6'd0, 32'd4, 0, 0, 0, 0, 1);
    v.rd = 5'd21;
    drive(v);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_result", bus.out_result, 32'd2);
      chk("bp_out_rd", 32'(bus.out_rd), 32'd20);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    sample();
    chk("bp_drain_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(to_exp(v, 101, cyc + 1));
    tick();
    bus.in_valid = 1'b0;
    drain(101);

    // Flush in BUSY cycle 10 discards the multiply.
    send(mk(0, 0, 32'd6, 32'd7, 0, 0, C_MUL, 32'd42, 0, 0, 0, 0, 0), 1'b0, 102);
    repeat (9) tick();
    flush = 1'b1;
    sample();
    chk("flush_md_busy_before", 32'(bus.md_busy), 32'd1);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    sample();
    chk("flush_md_busy_after", 32'(bus.md_busy), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      sample();
      if (bus.out_valid) cnt++;
      tick();
    end
    chk("flush_no_result", 32'(cnt), 32'd0);

    // Flush in IDLE blocks an offered op for that cycle.
    v = mk(0, 0, 32'd2, 32'd3, 0, 0, 6'd0, 32'd5, 0, 0, 0, 0, 1);
    v.rd = 5'd7;
    drive(v);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    sample();
    chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    send(v, 1'b1, 103);
    drain(103);

    // Asynchronous reset in the middle of a multiply.
    send(mk(0, 0, 32'hFFFFFFFD, 32'd7, 0, 0, C_MUL, 0, 0, 0, 0, 0, 0), 1'b0, 104);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mid_out_result", bus.out_result, 32'd0);
    chk("rst_mid_out_rd", 32'(bus.out_rd), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    sample();
    chk("rst_mid_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_release_md_busy", 32'(bus.md_busy), 32'd0);
    tick();
    for (int k = 0; k < 40; k++) begin
      sample();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
